// File: rtl/vga_text_pkg.sv
// Shared geometry constants and clear-engine state encoding for the VGA text buffer,
// used by the buffer itself, the tile renderer and the AXI-lite slave.
package vga_text_pkg;

  localparam int H_TILES        = 80;
  localparam int V_TILES        = 30;
  localparam int CHAR_BITS      = 7;
  localparam int CHARS_PER_WORD = 4;
  localparam int WORDS_PER_ROW  = H_TILES / CHARS_PER_WORD;
  localparam int NUM_ADDRS      = WORDS_PER_ROW * V_TILES;
  localparam int DATA_WIDTH     = CHAR_BITS * CHARS_PER_WORD;
  localparam int ADDR_WIDTH     = $clog2(NUM_ADDRS);
  localparam int ROW_WIDTH      = $clog2(V_TILES);
  localparam int COL_WIDTH      = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/vga_text_clear_fsm.sv
// Self-timed screen clear engine: sweeps every word once with the latched fill
// character and presents a write port the buffer muxes over the host write port.
module vga_text_clear_fsm
  import vga_text_pkg::*;
#(
  parameter int NUM_ADDRS      = vga_text_pkg::NUM_ADDRS,
  parameter int ADDR_WIDTH     = vga_text_pkg::ADDR_WIDTH,
  parameter int CHAR_BITS      = vga_text_pkg::CHAR_BITS,
  parameter int CHARS_PER_WORD = vga_text_pkg::CHARS_PER_WORD
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clr_req_i,
  input  logic [CHAR_BITS-1:0]                fill_i,
  output logic                                busy_o,
  output logic                                clr_done_o,
  output clr_state_e                          state_o,
  output logic                                clr_we_o,
  output logic [ADDR_WIDTH-1:0]               clr_addr_o,
  output logic [CHAR_BITS*CHARS_PER_WORD-1:0] clr_data_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDRS - 1);

  clr_state_e             state_q;
  logic [ADDR_WIDTH-1:0]  cnt_q;
  logic [CHAR_BITS-1:0]   fill_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CLR_IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      busy_o     <= 1'b0;
      clr_done_o <= 1'b0;
    end else begin
      clr_done_o <= 1'b0;
      unique case (state_q)
        CLR_IDLE: begin
          if (clr_req_i) begin
            fill_q  <= fill_i;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= CLR_CLEAR;
          end
        end
        CLR_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            cnt_q      <= '0;
            busy_o     <= 1'b0;
            clr_done_o <= 1'b1;
            state_q    <= CLR_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CLR_DONE: state_q <= CLR_IDLE;
        default:  state_q <= CLR_IDLE;
      endcase
    end
  end

  assign state_o    = state_q;
  assign clr_we_o   = (state_q == CLR_CLEAR);
  assign clr_addr_o = cnt_q;
  assign clr_data_o = {CHARS_PER_WORD{fill_q}};

endmodule

// File: rtl/vga_text_buffer.sv
// Text-mode screen buffer: masked host writes, registered AXI read-back, two-stage
// scrolled display read and a clear engine. Build option: VGA_BUF_CLEAR_BLANK_EN.
module vga_text_buffer
  import vga_text_pkg::*;
#(
  parameter int H_TILES        = vga_text_pkg::H_TILES,
  parameter int V_TILES        = vga_text_pkg::V_TILES,
  parameter int CHAR_BITS      = vga_text_pkg::CHAR_BITS,
  parameter int CHARS_PER_WORD = vga_text_pkg::CHARS_PER_WORD,
  parameter int WORDS_PER_ROW  = H_TILES / CHARS_PER_WORD,
  parameter int NUM_ADDRS      = WORDS_PER_ROW * V_TILES,
  parameter int DATA_WIDTH     = CHAR_BITS * CHARS_PER_WORD,
  parameter int ADDR_WIDTH     = $clog2(NUM_ADDRS),
  parameter int ROW_WIDTH      = $clog2(V_TILES),
  parameter int COL_WIDTH      = $clog2(WORDS_PER_ROW)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [ADDR_WIDTH-1:0]     w_addr_i,
  input  logic [CHARS_PER_WORD-1:0] w_strb_i,
  input  logic [DATA_WIDTH-1:0]     din_i,
  input  logic                      r_req_i,
  input  logic [ADDR_WIDTH-1:0]     r_addr_i,
  output logic [DATA_WIDTH-1:0]     r_data_o,
  output logic                      r_valid_o,
  input  logic [ROW_WIDTH-1:0]      vr_row_i,
  input  logic [COL_WIDTH-1:0]      vr_col_i,
  output logic [DATA_WIDTH-1:0]     dout_o,
  input  logic                      scroll_we_i,
  input  logic [ROW_WIDTH-1:0]      scroll_i,
  input  logic                      clr_req_i,
  input  logic [CHAR_BITS-1:0]      fill_i,
  output logic                      busy_o,
  output logic                      clr_done_o
);

  // Limits one bit wider than the operands so power-of-two geometries still compare.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_ADDRS);
  localparam logic [ROW_WIDTH:0]  ROW_LIMIT  = (ROW_WIDTH + 1)'(V_TILES);
  localparam logic [COL_WIDTH:0]  COL_LIMIT  = (COL_WIDTH + 1)'(WORDS_PER_ROW);

  logic [DATA_WIDTH-1:0] mem [NUM_ADDRS];

  clr_state_e            clr_state;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;

  vga_text_clear_fsm #(
    .NUM_ADDRS      (NUM_ADDRS),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CHAR_BITS      (CHAR_BITS),
    .CHARS_PER_WORD (CHARS_PER_WORD)
  ) u_clear (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_req_i  (clr_req_i),
    .fill_i     (fill_i),
    .busy_o     (busy_o),
    .clr_done_o (clr_done_o),
    .state_o    (clr_state),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_data_o (clr_data)
  );

  logic host_wr_ok;
  logic host_rd_ok;

  assign host_wr_ok = wr_en_i && (clr_state == CLR_IDLE) && ({1'b0, w_addr_i} < ADDR_LIMIT);
  assign host_rd_ok = {1'b0, r_addr_i} < ADDR_LIMIT;

  // The clear port only drives in CLEAR, where host writes are already blocked.
  // NOTE: memory has no reset so it maps onto block RAM; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= clr_data;
    end else if (host_wr_ok) begin
      for (int k = 0; k < CHARS_PER_WORD; k++) begin
        if (w_strb_i[k]) begin
          mem[w_addr_i][k*CHAR_BITS +: CHAR_BITS] <= din_i[k*CHAR_BITS +: CHAR_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else begin
      r_valid_o <= r_req_i;
      if (r_req_i) begin
        r_data_o <= host_rd_ok ? mem[r_addr_i] : '0;
      end
    end
  end

  logic [ROW_WIDTH-1:0] scroll_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scroll_q <= '0;
    end else if (scroll_we_i && ({1'b0, scroll_i} < ROW_LIMIT)) begin
      scroll_q <= scroll_i;
    end
  end

  logic [ROW_WIDTH:0]    row_sum;
  logic [ROW_WIDTH-1:0]  phys_row;
  logic [ADDR_WIDTH-1:0] phys_addr;
  logic                  vr_ok;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    row_sum  = {1'b0, vr_row_i} + {1'b0, scroll_q};
    phys_row = row_sum[ROW_WIDTH-1:0];
    if (row_sum >= ROW_LIMIT) begin
      phys_row = ROW_WIDTH'(row_sum - ROW_LIMIT);
    end
    phys_addr = ADDR_WIDTH'(phys_row) * ADDR_WIDTH'(WORDS_PER_ROW) + ADDR_WIDTH'(vr_col_i);
    vr_ok     = ({1'b0, vr_row_i} < ROW_LIMIT) && ({1'b0, vr_col_i} < COL_LIMIT);
  end

  logic [ADDR_WIDTH-1:0] phys_addr_q;
  logic                  vr_ok_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phys_addr_q <= '0;
      vr_ok_q     <= 1'b0;
      dout_o      <= '0;
    end else begin
      phys_addr_q <= phys_addr;
      vr_ok_q     <= vr_ok;
`ifdef VGA_BUF_CLEAR_BLANK_EN
      if (busy_o) begin
        dout_o <= clr_data;
      end else begin
        dout_o <= vr_ok_q ? mem[phys_addr_q] : '0;
      end
`else
      dout_o <= vr_ok_q ? mem[phys_addr_q] : '0;
`endif
    end
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
// Directed bench for vga_text_buffer: masked writes, AXI read-back, scrolled display
// reads, clear sweep with mid-clear traffic, and reset during a clear.
module tb_vga_text_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [9:0]  w_addr_i;
  logic [3:0]  w_strb_i;
  logic [27:0] din_i;
  logic        r_req_i;
  logic [9:0]  r_addr_i;
  logic [27:0] r_data_o;
  logic        r_valid_o;
  logic [4:0]  vr_row_i;
  logic [4:0]  vr_col_i;
  logic [27:0] dout_o;
  logic        scroll_we_i;
  logic [4:0]  scroll_i;
  logic        clr_req_i;
  logic [6:0]  fill_i;
  logic        busy_o;
  logic        clr_done_o;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk_i = ~clk_i;

  vga_text_buffer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en_i     (wr_en_i),
    .w_addr_i    (w_addr_i),
    .w_strb_i    (w_strb_i),
    .din_i       (din_i),
    .r_req_i     (r_req_i),
    .r_addr_i    (r_addr_i),
    .r_data_o    (r_data_o),
    .r_valid_o   (r_valid_o),
    .vr_row_i    (vr_row_i),
    .vr_col_i    (vr_col_i),
    .dout_o      (dout_o),
    .scroll_we_i (scroll_we_i),
    .scroll_i    (scroll_i),
    .clr_req_i   (clr_req_i),
    .fill_i      (fill_i),
    .busy_o      (busy_o),
    .clr_done_o  (clr_done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] fill_word(input logic [6:0] c);
    return {4{c}};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_word(input logic [9:0] a, input logic [27:0] d, input logic [3:0] s);
    wr_en_i  = 1'b1;
    w_addr_i = a;
    din_i    = d;
    w_strb_i = s;
    tick();
    wr_en_i  = 1'b0;
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [27:0] d, output logic v);
    r_req_i  = 1'b1;
    r_addr_i = a;
    tick();
    d        = r_data_o;
    v        = r_valid_o;
    r_req_i  = 1'b0;
  endtask

  task automatic disp_read(input logic [4:0] row, input logic [4:0] col, output logic [27:0] d);
    vr_row_i = row;
    vr_col_i = col;
    tick();
    tick();
    d = dout_o;
  endtask

  task automatic set_scroll(input logic [4:0] s);
    scroll_we_i = 1'b1;
    scroll_i    = s;
    tick();
    scroll_we_i = 1'b0;
  endtask

  // Optional probes: a dropped write to addr 0, AXI reads of a swept and an unswept
  // address, and a display sample of addr 500 (row 25, col 0, scroll 0).
  task automatic run_clear(input logic [6:0] fill, input bit probe);
    int          n;
    logic [27:0] fw;
    fw        = fill_word(fill);
    fill_i    = fill;
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    check("clr_busy_rise", busy_o, 1);
    n = 0;
    while (busy_o === 1'b1 && n < 2000) begin
      if (probe) begin
        wr_en_i  = (n == 50);
        w_addr_i = 10'd0;
        din_i    = 28'h0123456;
        w_strb_i = 4'hF;
        r_req_i  = (n == 100) || (n == 101);
        r_addr_i = (n == 100) ? 10'd10 : 10'd500;
      end
      tick();
      n++;
      if (probe && n == 101) check("clr_rd_swept", r_data_o, fw);
      if (probe && n == 102) check("clr_rd_unswept", r_data_o, 28'h2AAAAAA);
`ifdef VGA_BUF_CLEAR_BLANK_EN
      if (probe && n == 120) check("clr_dout_blank", dout_o, fw);
`else
      if (probe && n == 120) check("clr_dout_mem", dout_o, 28'h2AAAAAA);
`endif
    end
    wr_en_i = 1'b0;
    r_req_i = 1'b0;
    check("clr_busy_cycles", n, 600);
    check("clr_done_pulse", clr_done_o, 1);
    tick();
    check("clr_done_width", clr_done_o, 0);
    check("clr_busy_after", busy_o, 0);
  endtask

  initial begin
    logic [27:0] d;
    logic        v;
    bit          done_seen;

    rst_i = 1'b1; wr_en_i = 1'b0; w_addr_i = '0; w_strb_i = '0; din_i = '0;
    r_req_i = 1'b0; r_addr_i = '0; vr_row_i = '0; vr_col_i = '0;
    scroll_we_i = 1'b0; scroll_i = '0; clr_req_i = 1'b0; fill_i = '0;
    repeat (3) tick();
    check("rst_r_data", r_data_o, 0);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_dout", dout_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", clr_done_o, 0);
    rst_i = 1'b0;
    tick();

    run_clear(7'h00, 1'b0);

    // Strobe 0101 keeps chars 0 and 2 of 0x0ABCDEF over zeroed memory.
    write_word(10'd5, 28'h0ABCDEF, 4'b0101);
    axi_read(10'd5, d, v);
    check("rd_strb_data", d, 28'h00BC06F);
    check("rd_strb_valid", v, 1);
    tick();
    check("rd_valid_drop", r_valid_o, 0);
    axi_read(10'd600, d, v);
    check("rd_oob_data", d, 0);
    check("rd_oob_valid", v, 1);

    write_word(10'd6, 28'h1234567, 4'hF);
    wr_en_i = 1'b1; w_addr_i = 10'd6; din_i = 28'h7654321; w_strb_i = 4'hF;
    r_req_i = 1'b1; r_addr_i = 10'd6;
    tick();
    wr_en_i = 1'b0; r_req_i = 1'b0;
    check("rdw_old", r_data_o, 28'h1234567);
    axi_read(10'd6, d, v);
    check("rdw_new", d, 28'h7654321);

    write_word(10'd0,   28'h1111111, 4'hF);
    write_word(10'd579, 28'h0579579, 4'hF);
    write_word(10'd580, 28'h0580580, 4'hF);
    write_word(10'd599, 28'h0599599, 4'hF);
    write_word(10'd500, 28'h2AAAAAA, 4'hF);
    set_scroll(5'd29);
    disp_read(5'd31, 5'd0, d);
    check("disp_oob_row", d, 0);
    vr_row_i = 5'd1; vr_col_i = 5'd0;
    tick();
    check("disp_latency", dout_o, 0);
    tick();
    check("disp_wrap", dout_o, 28'h1111111);

    // scroll 30 is rejected: row 29 stays at phys row 28 (addr 579).
    set_scroll(5'd30);
    disp_read(5'd29, 5'd19, d);
    check("scroll_ignored", d, 28'h0579579);
    disp_read(5'd0, 5'd0, d);
    check("scroll_row0", d, 28'h0580580);
    set_scroll(5'd0);
    disp_read(5'd29, 5'd19, d);
    check("disp_last_addr", d, 28'h0599599);
    disp_read(5'd0, 5'd20, d);
    check("disp_oob_col", d, 0);

    vr_row_i = 5'd25; vr_col_i = 5'd0;
    run_clear(7'h20, 1'b1);
    for (int a = 0; a < 600; a++) begin
      axi_read(10'(a), d, v);
      check($sformatf("sweep_%0d", a), d, fill_word(7'h20));
    end

    write_word(10'd299, 28'h3333333, 4'hF);
    write_word(10'd301, 28'h5555555, 4'hF);
    fill_i    = 7'h41;
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    repeat (300) tick();
    check("mid_busy_before_rst", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid_busy_rst", busy_o, 0);
    check("mid_done_rst", clr_done_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    done_seen = 1'b0;
    repeat (700) begin
      tick();
      if (clr_done_o === 1'b1 || busy_o === 1'b1) done_seen = 1'b1;
    end
    check("mid_no_resume", done_seen, 0);
    axi_read(10'd299, d, v);
    check("mid_addr299", d, fill_word(7'h41));
    axi_read(10'd301, d, v);
    check("mid_addr301", d, 28'h5555555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
